// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - pipeline hazard detection, stall/flush control and operand forwarding
// Optional stall statistics counter enabled by defining HAZARD_STATS_EN.
module hazard_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        idex_memread,
    input  logic        idex_regwrite,
    input  logic [4:0]  idex_rd,
    input  logic [4:0]  idex_rs1,
    input  logic [4:0]  idex_rs2,
    input  logic [4:0]  ifid_rs1,
    input  logic [4:0]  ifid_rs2,
    input  logic        ifid_uses_rs2,
    input  logic        exmem_regwrite,
    input  logic [4:0]  exmem_rd,
    input  logic        memwb_regwrite,
    input  logic [4:0]  memwb_rd,
    input  logic        branch_taken,
    input  logic        mem_wait,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        idex_write,
    output logic        idex_bubble,
    output logic        ifid_flush,
    output logic [1:0]  forward_a,
    output logic [1:0]  forward_b,
    output logic [1:0]  hazard_state,
    output logic [31:0] stall_count
);

    localparam logic [1:0] ST_RUN      = 2'b00;
    localparam logic [1:0] ST_LU_STALL = 2'b01;
    localparam logic [1:0] ST_FLUSH    = 2'b10;
    localparam logic [1:0] ST_MEM_WAIT = 2'b11;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    logic [1:0] hazard_state_q;
    logic [1:0] hazard_state_d;
    logic       lu_hit;
    logic       lu_active;

    // The cycle after a load-use stall the load has moved on, so the match is stale.
    always_comb begin
        lu_hit = idex_memread && (idex_rd != 5'd0) &&
                 ((idex_rd == ifid_rs1) || (ifid_uses_rs2 && (idex_rd == ifid_rs2)));
        lu_active = lu_hit && (hazard_state_q != ST_LU_STALL);
    end

    always_comb begin
        pc_write       = 1'b1;
        ifid_write     = 1'b1;
        idex_write     = 1'b1;
        idex_bubble    = 1'b0;
        ifid_flush     = 1'b0;
        hazard_state_d = ST_RUN;
        if (rst) begin
            hazard_state_d = ST_RUN;
        end else if (mem_wait) begin
            pc_write       = 1'b0;
            ifid_write     = 1'b0;
            idex_write     = 1'b0;
            hazard_state_d = ST_MEM_WAIT;
        end else if (branch_taken) begin
            ifid_flush     = 1'b1;
            idex_bubble    = 1'b1;
            hazard_state_d = ST_FLUSH;
        end else if (lu_active) begin
            pc_write       = 1'b0;
            ifid_write     = 1'b0;
            idex_bubble    = 1'b1;
            hazard_state_d = ST_LU_STALL;
        end
    end

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == rs))
            return FWD_EXMEM;
        else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == rs))
            return FWD_MEMWB;
        else
            return FWD_RF;
    endfunction

    always_comb begin
        forward_a = FWD_RF;
        forward_b = FWD_RF;
        if (!rst) begin
            forward_a = fwd_sel(idex_rs1);
            forward_b = fwd_sel(idex_rs2);
        end
    end

    always_ff @(posedge clk) begin
        hazard_state_q <= hazard_state_d;
    end

    assign hazard_state = hazard_state_q;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_count_q;
    logic [31:0] stall_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        if (rst)
            stall_count_d = 32'd0;
        else if ((!pc_write || idex_bubble) && (stall_count_q != 32'hFFFF_FFFF))
            stall_count_d = stall_count_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        stall_count_q <= stall_count_d;
    end

    assign stall_count = stall_count_q;
`else
    assign stall_count = 32'd0;
`endif

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 clk, input, 1: rising-edge clock for all state.
REQ-003 rst, input, 1: synchronous active-high reset.
REQ-004 idex_memread / idex_regwrite, input, 1 each: control bits from the ID/EX pipeline register outputs.
REQ-005 idex_rd / idex_rs1 / idex_rs2, input, 5 each: register indices from the ID/EX outputs.
REQ-006 ifid_rs1 / ifid_rs2, input, 5 each: source indices of the instruction currently in ID.
REQ-007 ifid_uses_rs2, input, 1: the ID instruction reads rs2.
REQ-008 exmem_regwrite / memwb_regwrite, input, 1 each; exmem_rd / memwb_rd, input, 5 each: later-stage writeback info.
REQ-009 branch_taken, input, 1: EX-stage redirect.
REQ-010 mem_wait, input, 1: data memory busy.
REQ-011 pc_write / ifid_write / idex_write, output, 1 each: stage enables.
REQ-012 idex_bubble, output, 1: forces all ID/EX control inputs to 0.
REQ-013 ifid_flush, output, 1: clears IF/ID.
REQ-014 forward_a / forward_b, output, 2 each: EX operand select (00 = regfile, 10 = EX/MEM, 01 = MEM/WB).
REQ-015 hazard_state, output, 2: registered FSM state.
REQ-016 stall_count, output, 32: stall statistics counter.

Function
REQ-017 Load-use hazard (LU) SHALL be flagged when idex_memread=1, idex_rd!=0, and either idex_rd==ifid_rs1, or ifid_uses_rs2=1 and idex_rd==ifid_rs2.
REQ-018 Control outputs SHALL be combinational from hazard_state and the current inputs, so hazard response has zero-cycle latency.
REQ-019 Priority SHALL be: rst > mem_wait > branch_taken > LU > normal.
REQ-020 In normal operation, pc_write, ifid_write and idex_write SHALL be 1, and idex_bubble and ifid_flush SHALL be 0.
REQ-021 When mem_wait=1, pc_write, ifid_write and idex_write SHALL be 0; bubble and flush SHALL be 0.
REQ-022 When branch_taken=1 (and mem_wait=0), ifid_flush and idex_bubble SHALL be 1, and pc_write SHALL be 1.
REQ-023 When LU is flagged (with mem_wait=0 and branch_taken=0), pc_write and ifid_write SHALL be 0, and idex_bubble SHALL be 1.
REQ-024 FSM states SHALL be encoded RUN=00, LU_STALL=01, FLUSH=10, MEM_WAIT=11, with the next state chosen by the REQ-019 priority.
REQ-025 From LU_STALL, the FSM SHALL return to RUN on the next edge unless a higher-priority event occurs; LU SHALL be ignored for exactly one cycle while in LU_STALL.
REQ-026 FLUSH SHALL last one cycle, then return to RUN, or go to LU_STALL if LU is flagged.
REQ-027 MEM_WAIT SHALL persist while mem_wait=1; when mem_wait falls, the FSM SHALL go to RUN and detection SHALL resume that cycle.
REQ-028 forward_a SHALL be 10 if exmem_regwrite=1, exmem_rd!=0 and exmem_rd==idex_rs1.
REQ-029 Otherwise, forward_a SHALL be 01 if memwb_regwrite=1, memwb_rd!=0 and memwb_rd==idex_rs1; otherwise 00.
REQ-030 forward_b SHALL be computed the same way using idex_rs2.
REQ-031 Forwarding SHALL be evaluated every cycle, independent of stall state; the EX/MEM match SHALL win over the MEM/WB match.
REQ-032 Register x0 SHALL never trigger a hazard or a forward.

Reset
REQ-033 While rst=1 at a clock edge, hazard_state SHALL become RUN and stall_count SHALL become 0.
REQ-034 During rst, the enable outputs SHALL be 1, bubble and flush SHALL be 0, and forward_a/forward_b SHALL be 00.
REQ-035 rst asserted mid-stall or mid-wait SHALL abort the stall or wait, with no residual bubble.

Configuration
REQ-036 With HAZARD_STATS_EN defined, stall_count SHALL increment by 1 on each clock where pc_write=0 or idex_bubble=1, and SHALL saturate at 0xFFFFFFFF.
REQ-037 Without HAZARD_STATS_EN, stall_count SHALL be tied to 0 and no counter logic SHALL be present.

Verification
REQ-038 Load x5 in ID/EX with ifid_rs1=5 -> one cycle with pc_write=0, ifid_write=0, idex_bubble=1; hazard_state 00->01->00.
REQ-039 Same LU condition but idex_rd=0 -> no stall; outputs stay at normal values.
REQ-040 branch_taken=1 together with LU -> ifid_flush=1, idex_bubble=1, pc_write=1; next state is FLUSH (10).
REQ-041 mem_wait held high for 3 cycles during LU -> all enables 0 for 3 cycles, state 11; then LU stall resolves with 1 bubble.
REQ-042 exmem_rd=memwb_rd=7 with both regwrite=1 and idex_rs1=7 -> forward_a=10; clear exmem_regwrite -> forward_a=01.
REQ-043 With HAZARD_STATS_EN, preload 0xFFFFFFFE and run 3 stall cycles -> stall_count=0xFFFFFFFF; then rst -> stall_count=0.
